instr_encoder: RTL and testbench

Builds 32-bit instruction words, in the format the control unit decodes, from separate opcode and operand fields. Accepted requests pass through a small FIFO. The block then writes each word into instruction memory at consecutive addresses through a write/ack handshake. It sits between the program loader or debug port and instruction memory.

---
 rtl/isa_pkg.sv | 29 ++
 rtl/instr_encoder_if.sv | 31 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - instruction-set constants and form decode shared with control_unit
// Purpose: class codes, instruction field bit positions, class legality and
//          register/immediate form decode used by encoder and decoder alike.
// Ports:   none (package).
package isa_pkg;

  localparam logic [2:0] ARITH = 3'd0;
  localparam logic [2:0] JUMP  = 3'd3;
  localparam logic [2:0] LOGIC = 3'd6;
  localparam logic [2:0] SHIFT = 3'd7;

  localparam int CLASS_LSB = 29;
  localparam int SUB_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;

  function automatic logic is_legal_class(input logic [2:0] cls);
    return (cls == ARITH) || (cls == JUMP) || (cls == LOGIC) || (cls == SHIFT);
  endfunction

  // Only meaningful for non-jump classes; jump uses its own target form.
  function automatic logic is_imm_form(input logic [2:0] cls, input logic [1:0] sub);
    return (cls == SHIFT) || ((cls == ARITH) && (sub == 2'd1)) || ((cls == LOGIC) && sub[1]);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory write bus of instr_encoder
// Purpose: groups the request handshake/fields and the memory write/ack handshake.
// Ports:   master = loader plus instruction memory (drives request and mem_ack),
//          slave  = instr_encoder (drives in_ready and the memory write request).
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [1:0]        in_sub;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_class, in_sub, in_rd, in_rs, in_rt, in_imm, in_target, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_sub, in_rd, in_rs, in_rt, in_imm, in_target, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter
// Purpose: stores WIDTH-bit entries, first-word-fall-through head on dout.
// Ports:   clk, rst_n (async active-low), clear (sync flush), push/din, pop/dout,
//          full, empty, level (occupancy 0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction words and writes them to instruction memory
// Purpose: encodes accepted requests into 32-bit words, queues them in a FIFO and
//          writes them to consecutive instruction-memory addresses via write/ack.
// Ports:   clk, rst_n (async active-low), clear (sync flush),
//          bus (slave: request handshake + fields, memory write/ack),
//          err (illegal class dropped), wrapped (address wrapped to 0), level (FIFO occupancy).
module instr_encoder
  import isa_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  instr_encoder_if.slave         bus,
  output logic                   err,
  output logic                   wrapped,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [31:0]       word;
  logic [31:0]       head;
  logic              legal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    word = '0;
    word[CLASS_LSB +: 3] = bus.in_class;
    word[SUB_LSB +: 2]   = bus.in_sub;
    if (bus.in_class == JUMP) begin
      word[TGT_LSB +: 27] = bus.in_target;
    end else begin
      word[RD_LSB +: 5] = bus.in_rd;
      word[RS_LSB +: 5] = bus.in_rs;
      if (is_imm_form(bus.in_class, bus.in_sub)) word[IMM_LSB +: 17] = bus.in_imm;
      else                                       word[RT_LSB +: 5]   = bus.in_rt;
    end
  end

  assign legal        = is_legal_class(bus.in_class);
  assign bus.in_ready = !full && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  // Illegal classes are still handshaken so the loader never stalls on them.
  assign push         = accept && legal;
  assign pop          = (state == WRITE) && bus.mem_ack && !clear;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_we_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      err      <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      err     <= accept && !legal;
      wrapped <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        mem_we_q <= 1'b0;
        addr_q   <= BASE_ADDR;
      end else begin
        case (state)
          IDLE: begin
            if (!empty) begin
              state    <= WRITE;
              mem_we_q <= 1'b1;
            end
          end
          WRITE: begin
            if (bus.mem_ack) begin
              addr_q  <= addr_q + ADDR_W'(1);
              wrapped <= &addr_q;
              // An entry remains if more than the head was queued or one arrives now.
              if (!push && (level == LVL_W'(1))) begin
                state    <= IDLE;
                mem_we_q <= 1'b0;
              end
            end
          end
          default: begin
            state    <= IDLE;
            mem_we_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_we_q ? head : 32'd0;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  c;
    logic [1:0]  s;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic [31:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;
  logic v0 = 1'b0;
  logic v1 = 1'b0;
  logic ack0 = 1'b0;
  logic ack1 = 1'b0;
  logic [2:0]  f_class = '0;
  logic [1:0]  f_sub = '0;
  logic [4:0]  f_rd = '0;
  logic [4:0]  f_rs = '0;
  logic [4:0]  f_rt = '0;
  logic [16:0] f_imm = '0;
  logic [26:0] f_tgt = '0;

  logic       err0, err1, wrap0, wrap1;
  logic [2:0] level0, level1;

  int n_cmp = 0;
  int n_bad = 0;
  int err0_cnt = 0;
  int wrap0_cnt = 0;
  int wrap1_cnt = 0;

  logic [41:0] q0[$];
  logic [41:0] q1[$];
  logic [41:0] e0, e1;
  logic [9:0]  ea0 = 10'd0;
  logic [9:0]  ea1 = 10'd1023;

  vec_t tbl [7];

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(10)) b0 ();
  instr_encoder_if #(.ADDR_W(10)) b1 ();

  assign b0.in_valid = v0;   assign b1.in_valid = v1;
  assign b0.mem_ack  = ack0; assign b1.mem_ack  = ack1;
  assign b0.in_class = f_class; assign b1.in_class = f_class;
  assign b0.in_sub   = f_sub;   assign b1.in_sub   = f_sub;
  assign b0.in_rd    = f_rd;    assign b1.in_rd    = f_rd;
  assign b0.in_rs    = f_rs;    assign b1.in_rs    = f_rs;
  assign b0.in_rt    = f_rt;    assign b1.in_rt    = f_rt;
  assign b0.in_imm   = f_imm;   assign b1.in_imm   = f_imm;
  assign b0.in_target = f_tgt;  assign b1.in_target = f_tgt;

  instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(10'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(b0.slave),
    .err(err0), .wrapped(wrap0), .level(level0)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(10'd1023)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(b1.slave),
    .err(err1), .wrapped(wrap1), .level(level1)
  );

  // Monitors: a write completes on the next rising edge when mem_we && mem_ack.
  always @(negedge clk) begin
    if (rst_n && b0.mem_we && b0.mem_ack && !clear0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL wr0: got addr=%0d data=%h, expected no write", b0.mem_addr, b0.mem_wdata);
      end else begin
        e0 = q0.pop_front();
        if ({b0.mem_addr, b0.mem_wdata} !== e0) begin
          n_bad++;
          $display("FAIL wr0: got addr=%0d data=%h, expected addr=%0d data=%h",
                   b0.mem_addr, b0.mem_wdata, e0[41:32], e0[31:0]);
        end
      end
    end
    if (wrap0 === 1'b1) wrap0_cnt++;
    if (err0 === 1'b1) err0_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n && b1.mem_we && b1.mem_ack && !clear1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL wr1: got addr=%0d data=%h, expected no write", b1.mem_addr, b1.mem_wdata);
      end else begin
        e1 = q1.pop_front();
        if ({b1.mem_addr, b1.mem_wdata} !== e1) begin
          n_bad++;
          $display("FAIL wr1: got addr=%0d data=%h, expected addr=%0d data=%h",
                   b1.mem_addr, b1.mem_wdata, e1[41:32], e1[31:0]);
        end
      end
    end
    if (wrap1 === 1'b1) wrap1_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drives one request, waits (bounded) for acceptance, returns 1 time unit after the accepting edge.
  task automatic send(input int which, input vec_t v);
    int   n;
    logic rdy;
    f_class = v.c; f_sub = v.s; f_rd = v.rd; f_rs = v.rs; f_rt = v.rt;
    f_imm = v.imm; f_tgt = v.tgt;
    if (which == 0) v0 = 1'b1; else v1 = 1'b1;
    n = 0;
    rdy = 1'b0;
    forever begin
      @(negedge clk);
      rdy = (which == 0) ? b0.in_ready : b1.in_ready;
      if (rdy) break;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        break;
      end
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    if (rdy && (v.c == 3'd0 || v.c == 3'd3 || v.c == 3'd6 || v.c == 3'd7)) begin
      if (which == 0) begin q0.push_back({ea0, v.w}); ea0 = ea0 + 10'd1; end
      else            begin q1.push_back({ea1, v.w}); ea1 = ea1 + 10'd1; end
    end
  endtask

  initial begin
    vec_t bad;
    tbl[0] = '{3'd0, 2'd0, 5'd3,  5'd4,  5'd5,  17'h00000, 27'h0000000, 32'h00C8_5000};
    tbl[1] = '{3'd0, 2'd1, 5'd1,  5'd2,  5'd0,  17'h1FFFF, 27'h0000000, 32'h0845_FFFF};
    tbl[2] = '{3'd3, 2'd2, 5'd9,  5'd9,  5'd9,  17'h00001, 27'h5A5A5A5, 32'h75A5_A5A5};
    tbl[3] = '{3'd6, 2'd1, 5'd31, 5'd0,  5'd31, 17'h01234, 27'h0000000, 32'hCFC1_F000};
    tbl[4] = '{3'd6, 2'd3, 5'd0,  5'd31, 5'd7,  17'h00001, 27'h0000000, 32'hD83E_0001};
    tbl[5] = '{3'd7, 2'd0, 5'd5,  5'd6,  5'd3,  17'h0ABCD, 27'h0000000, 32'hE14C_ABCD};
    tbl[6] = '{3'd0, 2'd3, 5'd2,  5'd1,  5'd7,  17'h1FFFF, 27'h0000000, 32'h1882_7000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
    chk("rst_mem_we", 32'(b0.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(b0.mem_addr), 32'd0);
    chk("rst_mem_wdata", b0.mem_wdata, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_wrapped", 32'(wrap0), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_addr_base1", 32'(b1.mem_addr), 32'd1023);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, mem_we from edge N+1.
    ack0 = 1'b1;
    send(0, tbl[0]);
    chk("lat_we_n", 32'(b0.mem_we), 32'd0);
    chk("lat_level_n", 32'(level0), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_we_n1", 32'(b0.mem_we), 32'd1);
    chk("lat_wdata_n1", b0.mem_wdata, 32'h00C8_5000);
    chk("lat_addr_n1", 32'(b0.mem_addr), 32'd0);

    for (int i = 1; i < 7; i++) send(0, tbl[i]);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_level", 32'(level0), 32'd0);
    chk("drain_addr", 32'(b0.mem_addr), 32'd7);

    // Illegal classes: accepted, err pulse, nothing queued.
    bad = tbl[0]; bad.c = 3'd2;
    send(0, bad);
    chk("ill2_err", 32'(err0), 32'd1);
    chk("ill2_level", 32'(level0), 32'd0);
    chk("ill2_we", 32'(b0.mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("ill2_err_low", 32'(err0), 32'd0);
    bad.c = 3'd5;
    send(0, bad);
    chk("ill5_err", 32'(err0), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-transfer drops mem_we at once and discards the FIFO.
    ack0 = 1'b0;
    send(0, tbl[4]);
    @(posedge clk);
    #1;
    chk("mid_we_high", 32'(b0.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(b0.mem_we), 32'd0);
    chk("mid_rst_level", 32'(level0), 32'd0);
    q0.delete();
    ea0 = 10'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: DEPTH accepts fill the FIFO, then one write per cycle.
    for (int i = 0; i < 4; i++) send(0, tbl[i]);
    chk("full_in_ready", 32'(b0.in_ready), 32'd0);
    chk("full_level", 32'(level0), 32'd4);
    chk("full_wdata_held", b0.mem_wdata, 32'h00C8_5000);
    chk("full_addr_held", 32'(b0.mem_addr), 32'd0);
    ack0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("burst_q0_empty", 32'(q0.size()), 32'd0);
    chk("burst_we_low", 32'(b0.mem_we), 32'd0);
    chk("burst_addr", 32'(b0.mem_addr), 32'd4);

    // Wrap on the instance based at 1023.
    ack1 = 1'b1;
    send(1, tbl[0]);
    send(1, tbl[1]);
    repeat (4) @(posedge clk);
    #1;
    chk("wrap_q1_empty", 32'(q1.size()), 32'd0);
    chk("wrap_pulses", 32'(wrap1_cnt), 32'd1);
    chk("wrap_addr", 32'(b1.mem_addr), 32'd1);

    // Clear during an unacked write.
    ack0 = 1'b0;
    send(0, tbl[5]);
    @(posedge clk);
    #1;
    chk("clr_we_before", 32'(b0.mem_we), 32'd1);
    clear0 = 1'b1;
    #1;
    chk("clr_in_ready", 32'(b0.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear0 = 1'b0;
    chk("clr_we", 32'(b0.mem_we), 32'd0);
    chk("clr_level", 32'(level0), 32'd0);
    chk("clr_addr", 32'(b0.mem_addr), 32'd0);
    q0.delete();
    ea0 = 10'd0;
    ack0 = 1'b1;
    send(0, tbl[6]);
    repeat (4) @(posedge clk);
    #1;
    chk("post_clr_q0", 32'(q0.size()), 32'd0);
    chk("err_pulses", 32'(err0_cnt), 32'd2);
    chk("no_wrap0", 32'(wrap0_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
